// File: rtl/ad_sync_pkg.sv
// ad_sync_pkg: shared constants and helpers for the
// multi-channel control-level synchroniser.
package ad_sync_pkg;

  localparam logic MODE_LEVEL   = 1'b0;
  localparam logic MODE_STRETCH = 1'b1;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 8;
  localparam int FILT_MIN = 1;
  localparam int FILT_MAX = 255;
  localparam int STR_MIN  = 1;
  localparam int STR_MAX  = 255;

  function automatic int cnt_w(input int x);
    return (x < 1) ? 1 : $clog2(x + 1);
  endfunction

endpackage

// File: rtl/ad_sync_chan.sv
// ad_sync_chan: one channel -- sync chain, consecutive-cycle
// filter, registered edge pulses and optional stretch.
module ad_sync_chan
  import ad_sync_pkg::*;
#(
  parameter int   SYNC_STAGES = 3,
  parameter int   FILTER_LEN  = 4,
  parameter int   STRETCH     = 8,
  parameter logic MODE_BIT    = MODE_LEVEL,
  parameter logic RST_BIT     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  input  logic en_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int FW = cnt_w(FILTER_LEN);
  localparam int SW = cnt_w(STRETCH);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   synced;
  logic                   load;

  assign synced = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], async_i};

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (synced != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = synced;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  // pulses are suppressed until the outputs are declared valid
  assign load   = (filt_d != filt_q);
  assign rise_d = en_i & load & synced;
  assign fall_d = en_i & load & ~synced;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RST_BIT}};
      fcnt_q <= '0;
      filt_q <= RST_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

  if (MODE_BIT == MODE_STRETCH) begin : g_str
    logic [SW-1:0] str_q, str_d;

    always_comb begin
      str_d = str_q;
      if (rise_d)              str_d = SW'(STRETCH);
      else if (str_q != '0)    str_d = str_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) str_q <= '0;
      else         str_q <= str_d;
    end

    assign lvl_o = (str_q != '0);
  end else begin : g_lvl
    assign lvl_o = filt_q;
  end

endmodule

// File: rtl/ad_multi_sync.sv
// ad_multi_sync: N-channel synchroniser into clk_dco_div with
// a shared warm-up counter that masks outputs after reset.
module ad_multi_sync
  import ad_sync_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 3,
  parameter int FILTER_LEN  = 4,
  parameter int STRETCH     = 8,
  parameter     MODE        = 4'b0010,
  parameter     RST_VAL     = 4'b0001
) (
  input  logic            clk_dco_div,
  input  logic            reset_n,
  input  logic [N_CH-1:0] async_in,
  output logic [N_CH-1:0] sync_out,
  output logic [N_CH-1:0] rise_pls,
  output logic [N_CH-1:0] fall_pls,
  output logic            out_valid
);

  localparam int WARM = SYNC_STAGES + FILTER_LEN;
  localparam int WW   = $clog2(WARM + 1);

  localparam logic [N_CH-1:0] MD = MODE;
  localparam logic [N_CH-1:0] RV = RST_VAL;

  if ($bits(MODE) != N_CH || $bits(RST_VAL) != N_CH) begin : g_e_w
    $error("MODE/RST_VAL width must equal N_CH");
  end
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_e_s
    $error("SYNC_STAGES out of range");
  end
  if (FILTER_LEN < FILT_MIN || FILTER_LEN > FILT_MAX) begin : g_e_f
    $error("FILTER_LEN out of range");
  end
  if (STRETCH < STR_MIN || STRETCH > STR_MAX) begin : g_e_t
    $error("STRETCH out of range");
  end
  if (N_CH < 1) begin : g_e_n
    $error("N_CH must be at least 1");
  end

  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            valid_q, valid_d;
  logic [N_CH-1:0] lvl;

  always_comb begin
    wcnt_d = wcnt_q;
    if (wcnt_q != WW'(WARM)) wcnt_d = wcnt_q + 1'b1;
    valid_d = valid_q | (wcnt_d == WW'(WARM));
  end

  always_ff @(posedge clk_dco_div or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      valid_q <= valid_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ad_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .STRETCH     (STRETCH),
      .MODE_BIT    (MD[i]),
      .RST_BIT     (RV[i])
    ) u_chan (
      .clk_i   (clk_dco_div),
      .rst_ni  (reset_n),
      .async_i (async_in[i]),
      .en_i    (valid_q),
      .lvl_o   (lvl[i]),
      .rise_o  (rise_pls[i]),
      .fall_o  (fall_pls[i])
    );
  end

  // a filtered/RST_VAL difference at warm-up end appears here, pulse-free
  assign sync_out  = valid_q ? lvl : RV;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ad_multi_sync.sv
// tb_ad_multi_sync: random and directed stimulus against an
// edge-indexed history model of the synchroniser.
module tb_ad_multi_sync;

  localparam int N    = 4;
  localparam int S    = 3;
  localparam int F    = 4;
  localparam int ST   = 8;
  localparam int WARM = S + F;
  localparam logic [3:0] MODE = 4'b0010;
  localparam logic [3:0] RV   = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ain = 4'b0001;
  logic [3:0] so, rp, fp;
  logic       ov;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ad_multi_sync #(
    .N_CH        (N),
    .SYNC_STAGES (S),
    .FILTER_LEN  (F),
    .STRETCH     (ST),
    .MODE        (MODE),
    .RST_VAL     (RV)
  ) dut (
    .clk_dco_div (clk),
    .reset_n     (rst_n),
    .async_in    (ain),
    .sync_out    (so),
    .rise_pls    (rp),
    .fall_pls    (fp),
    .out_valid   (ov)
  );

  // histories indexed by edge number since reset release
  logic [3:0] in_h[$];
  logic [3:0] syn_h[$];
  logic [3:0] filt_h[$];
  int         k;
  int         last_rise[4];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h",
               tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    in_h.delete();
    syn_h.delete();
    filt_h.delete();
    in_h.push_back(RV);
    syn_h.push_back(RV);
    filt_h.push_back(RV);
    k = 0;
    for (int i = 0; i < 4; i++) last_rise[i] = -1000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_sync_out", so, RV);
    check("rst_valid", ov, 1'b0);
    check("rst_pulses", {rp, fp}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // called at a negedge; drives v, takes one edge, checks
  task automatic step(input logic [3:0] v);
    logic [3:0] syn, old, nf, er, ef, eo;
    bit all;
    ain = v;
    @(posedge clk);
    k++;
    in_h.push_back(v);
    syn = (k - S + 1 >= 1) ? in_h[k-S+1] : RV;
    syn_h.push_back(syn);
    old = filt_h[k-1];
    nf  = old;
    for (int i = 0; i < 4; i++) begin
      if (k - F >= 0) begin
        all = 1'b1;
        for (int j = k - F; j < k; j++)
          if (syn_h[j][i] == old[i]) all = 1'b0;
        if (all) nf[i] = ~old[i];
      end
    end
    filt_h.push_back(nf);
    er = '0;
    ef = '0;
    for (int i = 0; i < 4; i++) begin
      if (k - 1 >= WARM && old[i] != nf[i]) begin
        if (nf[i]) begin
          er[i] = 1'b1;
          last_rise[i] = k;
        end else begin
          ef[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (k < WARM)     eo[i] = RV[i];
      else if (MODE[i]) eo[i] = (k - last_rise[i] < ST);
      else              eo[i] = nf[i];
    end
    #1;
    check("sync_out", so, eo);
    check("rise_pls", rp, er);
    check("fall_pls", fp, ef);
    check("out_valid", ov, (k >= WARM));
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    for (int c = 0; c < n; c++) step(v);
  endtask

  logic [3:0] rv;

  initial begin
    model_reset();
    do_reset();
    hold(4'b0001, 12);
    hold(4'b0101, 12);
    hold(4'b0001, 10);
    hold(4'b0101, 3);
    hold(4'b0001, 12);
    hold(4'b0101, 4);
    hold(4'b0001, 14);
    hold(4'b0011, 20);
    hold(4'b0001, 14);
    hold(4'b0011, 4);
    hold(4'b0001, 4);
    hold(4'b0011, 4);
    hold(4'b0001, 22);
    hold(4'b0011, 5);
    hold(4'b0001, 5);
    hold(4'b0011, 5);
    hold(4'b0001, 22);
    do_reset();
    hold(4'b0000, 12);
    hold(4'b0001, 8);
    hold(4'b0000, 12);
    hold(4'b0010, 10);
    do_reset();
    hold(4'b0001, 12);
    rv = 4'b0001;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) rv[i] = ~rv[i];
      step(rv);
      if ($urandom_range(0, 199) == 0) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
